// File: rtl/instr_fetch.sv
// instr_fetch: program counter owner and single-word instruction fetch with stale-fetch discard
module instr_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pcEn,
    input  logic                  pcIncOrSet,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  irEn,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memAck,
    input  logic [15:0]           memData,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           instruction,
    output logic                  fetchStall
);
    localparam logic [1:0] START = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] VALID = 2'd3;

    logic [1:0]            state, state_nxt;
    logic                  addr_ld;
    logic [15:0]           buffer;
    logic [ADDR_WIDTH-1:0] npc, pc_cur;

    assign npc        = pcIncOrSet ? target : pc + 1'b1;
    assign pc_cur     = pcEn ? npc : pc;
    assign memReq     = (state == REQ) | (state == DRAIN);
    assign fetchStall = irEn & (state != VALID);

    // next state, and whether a fresh request address is latched this cycle
    always_comb begin
        state_nxt = state;
        addr_ld   = 1'b0;
        case (state)
            START: begin
                state_nxt = REQ;
                addr_ld   = 1'b1;
            end
            REQ: begin
                state_nxt = memAck ? (pcEn ? REQ : VALID) : (pcEn ? DRAIN : REQ);
                addr_ld   = memAck & pcEn;
            end
            DRAIN: begin
                state_nxt = memAck ? REQ : DRAIN;
                addr_ld   = memAck;
            end
            default: begin
                state_nxt = pcEn ? REQ : VALID;
                addr_ld   = pcEn;
            end
        endcase
    end

    // state, pc, request address, fetch buffer and instruction register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= START;
            pc          <= RESET_PC;
            memAddr     <= RESET_PC;
            buffer      <= 16'h0000;
            instruction <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (pcEn) pc <= npc;
            if (addr_ld) memAddr <= pc_cur;
            if (state == REQ && memAck && !pcEn) buffer <= memData;
            if (state == VALID && irEn) instruction <= buffer;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a flag-based fetch model
module tb_instr_fetch;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pcEn = 1'b0, pcIncOrSet = 1'b0, irEn = 1'b0, memAck = 1'b0;
    logic [15:0] target = '0, memData = '0;
    logic        memReq, fetchStall;
    logic [15:0] memAddr, pc, instruction;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] m_pc, m_addr, m_buf, m_instr;
    logic        m_req, m_stale, m_valid, m_started;

    instr_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset), .pcEn(pcEn), .pcIncOrSet(pcIncOrSet),
        .target(target), .irEn(irEn), .memReq(memReq), .memAddr(memAddr),
        .memAck(memAck), .memData(memData), .pc(pc), .instruction(instruction),
        .fetchStall(fetchStall)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_pc = 16'h0000; m_addr = 16'h0000; m_buf = 16'h0000; m_instr = 16'h0000;
        m_req = 1'b0; m_stale = 1'b0; m_valid = 1'b0; m_started = 1'b0;
    endtask

    task automatic drive(input logic p, input logic s, input logic [15:0] t,
                         input logic i, input logic a, input logic [15:0] d);
        @(negedge clock);
        pcEn = p; pcIncOrSet = s; target = t; irEn = i; memAck = a; memData = d;
        #1;
    endtask

    task automatic tick();
        logic [15:0] newpc;
        @(posedge clock);
        if (reset) begin
            newpc = pcEn ? (pcIncOrSet ? target : m_pc + 16'd1) : m_pc;
            if (irEn && m_valid) m_instr = m_buf;
            if (!m_started) begin
                m_started = 1'b1; m_req = 1'b1; m_addr = newpc; m_stale = 1'b0;
            end else if (m_req) begin
                if (memAck) begin
                    if (!m_stale && !pcEn) begin
                        m_valid = 1'b1; m_buf = memData; m_req = 1'b0;
                    end else begin
                        m_addr = newpc; m_stale = 1'b0;
                    end
                end else if (pcEn) m_stale = 1'b1;
            end else if (pcEn) begin
                m_valid = 1'b0; m_req = 1'b1; m_addr = newpc;
            end
            m_pc = newpc;
        end
    endtask

    task automatic test_reset();
        model_reset();
        drive(0, 0, 16'h0, 1, 0, 16'h0);
        n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL reset_memReq got %b exp 0", memReq); end
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h exp 0000", pc); end
        n_checks++; if (memAddr !== 16'h0000) begin n_fail++; $display("FAIL reset_memAddr got %h exp 0000", memAddr); end
        n_checks++; if (instruction !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h exp 0000", instruction); end
        n_checks++; if (fetchStall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b exp 1", fetchStall); end
        drive(0, 0, 16'h0, 0, 0, 16'h0);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait();
        drive(0, 0, 16'h0, 0, 1, 16'h5123);
        n_checks++; if (memReq !== 1'b1) begin n_fail++; $display("FAIL first_req got %b exp 1", memReq); end
        n_checks++; if (memAddr !== 16'h0000) begin n_fail++; $display("FAIL first_addr got %h exp 0000", memAddr); end
        tick();
        drive(0, 0, 16'h0, 1, 0, 16'h0);
        n_checks++; if (fetchStall !== 1'b0) begin n_fail++; $display("FAIL zw_stall got %b exp 0", fetchStall); end
        n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL zw_req_valid got %b exp 0", memReq); end
        tick();
        drive(0, 0, 16'h0, 0, 0, 16'h0);
        n_checks++; if (instruction !== 16'h5123) begin n_fail++; $display("FAIL zw_instr got %h exp 5123", instruction); end
    endtask

    task automatic test_sequential_wrap();
        drive(1, 1, 16'h0010, 0, 0, 16'h0); tick();
        drive(0, 0, 16'h0, 0, 1, 16'h1010);
        n_checks++; if (memAddr !== 16'h0010) begin n_fail++; $display("FAIL seq_addr10 got %h exp 0010", memAddr); end
        tick();
        drive(1, 0, 16'h0, 0, 0, 16'h0); tick();
        drive(1, 1, 16'hFFFF, 0, 1, 16'hAAAA);
        n_checks++; if (pc !== 16'h0011) begin n_fail++; $display("FAIL seq_pc got %h exp 0011", pc); end
        n_checks++; if (memReq !== 1'b1 || memAddr !== 16'h0011) begin n_fail++; $display("FAIL seq_req got %b/%h exp 1/0011", memReq, memAddr); end
        tick();
        drive(1, 0, 16'h0, 0, 1, 16'hBBBB);
        n_checks++; if (memAddr !== 16'hFFFF) begin n_fail++; $display("FAIL reissue_addr got %h exp ffff", memAddr); end
        tick();
        drive(0, 0, 16'h0, 0, 1, 16'h0C0C);
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc got %h exp 0000", pc); end
        n_checks++; if (memAddr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr got %h exp 0000", memAddr); end
        tick();
    endtask

    task automatic test_jump();
        drive(1, 1, 16'h0200, 1, 0, 16'h0);
        n_checks++; if (fetchStall !== 1'b0) begin n_fail++; $display("FAIL jump_stall got %b exp 0", fetchStall); end
        tick();
        drive(0, 0, 16'h0, 1, 0, 16'h0);
        n_checks++; if (pc !== 16'h0200) begin n_fail++; $display("FAIL jump_pc got %h exp 0200", pc); end
        n_checks++; if (memReq !== 1'b1 || memAddr !== 16'h0200) begin n_fail++; $display("FAIL jump_req got %b/%h exp 1/0200", memReq, memAddr); end
        n_checks++; if (instruction !== 16'h0C0C) begin n_fail++; $display("FAIL jump_oldcap got %h exp 0c0c", instruction); end
        n_checks++; if (fetchStall !== 1'b1) begin n_fail++; $display("FAIL req_stall got %b exp 1", fetchStall); end
        tick();
        drive(0, 0, 16'h0, 1, 1, 16'hBEEF);
        n_checks++; if (instruction !== 16'h0C0C) begin n_fail++; $display("FAIL stall_hold got %h exp 0c0c", instruction); end
        tick();
        drive(0, 0, 16'h0, 1, 0, 16'h0); tick();
        drive(0, 0, 16'h0, 0, 0, 16'h0);
        n_checks++; if (instruction !== 16'hBEEF) begin n_fail++; $display("FAIL jump_newcap got %h exp beef", instruction); end
    endtask

    task automatic test_stale();
        drive(1, 1, 16'h0005, 0, 0, 16'h0); tick();
        drive(1, 1, 16'h0040, 0, 0, 16'h0);
        n_checks++; if (memAddr !== 16'h0005) begin n_fail++; $display("FAIL stale_addr0 got %h exp 0005", memAddr); end
        tick();
        drive(0, 0, 16'h0, 1, 0, 16'h0);
        n_checks++; if (memReq !== 1'b1 || memAddr !== 16'h0005) begin n_fail++; $display("FAIL stale_addr1 got %b/%h exp 1/0005", memReq, memAddr); end
        n_checks++; if (pc !== 16'h0040) begin n_fail++; $display("FAIL stale_pc got %h exp 0040", pc); end
        tick();
        drive(0, 0, 16'h0, 0, 1, 16'hDEAD);
        n_checks++; if (memAddr !== 16'h0005) begin n_fail++; $display("FAIL stale_addr2 got %h exp 0005", memAddr); end
        tick();
        drive(0, 0, 16'h0, 1, 1, 16'h4040);
        n_checks++; if (memReq !== 1'b1 || memAddr !== 16'h0040) begin n_fail++; $display("FAIL stale_newreq got %b/%h exp 1/0040", memReq, memAddr); end
        n_checks++; if (fetchStall !== 1'b1) begin n_fail++; $display("FAIL stale_stall got %b exp 1", fetchStall); end
        tick();
        drive(0, 0, 16'h0, 1, 0, 16'h0); tick();
        drive(0, 0, 16'h0, 0, 0, 16'h0);
        n_checks++; if (instruction !== 16'h4040) begin n_fail++; $display("FAIL stale_instr got %h exp 4040", instruction); end
    endtask

    task automatic test_async_reset();
        drive(1, 1, 16'h0033, 0, 0, 16'h0); tick();
        drive(0, 0, 16'h0, 0, 0, 16'h0);
        n_checks++; if (memReq !== 1'b1 || memAddr !== 16'h0033) begin n_fail++; $display("FAIL ar_pre got %b/%h exp 1/0033", memReq, memAddr); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL ar_req got %b exp 0", memReq); end
        n_checks++; if (pc !== 16'h0000 || instruction !== 16'h0000) begin n_fail++; $display("FAIL ar_state got pc %h ir %h exp 0000/0000", pc, instruction); end
        model_reset();
        drive(0, 0, 16'h0, 0, 0, 16'h0);
        reset = 1'b1;
        tick();
        drive(0, 0, 16'h0, 0, 0, 16'h0);
        n_checks++; if (memReq !== 1'b1 || memAddr !== 16'h0000) begin n_fail++; $display("FAIL ar_restart got %b/%h exp 1/0000", memReq, memAddr); end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 16'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16'($urandom));
            n_checks++; if (memReq !== m_req) begin n_fail++; $display("FAIL rnd_req cyc %0d got %b exp %b", k, memReq, m_req); end
            if (m_req) begin
                n_checks++; if (memAddr !== m_addr) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %h exp %h", k, memAddr, m_addr); end
            end
            n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h exp %h", k, pc, m_pc); end
            n_checks++; if (instruction !== m_instr) begin n_fail++; $display("FAIL rnd_instr cyc %0d got %h exp %h", k, instruction, m_instr); end
            n_checks++; if (fetchStall !== (irEn & ~m_valid)) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %b exp %b", k, fetchStall, irEn & ~m_valid); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_sequential_wrap();
        test_jump();
        test_stale();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
